// File: rtl/btb_branch_predictor_if.sv
// Fetch/execute bus of the BTB branch predictor.
// master: pipeline side (drives fetch PC and resolved-branch info)
// slave : predictor side (returns prediction, redirect and statistics)
interface btb_branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    // Fetch-stage lookup
    logic [XLEN-1:0] pc_f_i;
    logic            pred_hit_f_o;
    logic            pred_taken_f_o;
    logic [XLEN-1:0] pred_target_f_o;

    // Execute-stage resolution
    logic            br_valid_x_i;
    logic [XLEN-1:0] pc_x_i;
    logic            taken_x_i;
    logic [XLEN-1:0] target_x_i;
    logic            pred_taken_x_i;
    logic [XLEN-1:0] pred_target_x_i;
    logic            mispredict_x_o;
    logic [XLEN-1:0] redirect_pc_x_o;

    // Statistics
    logic [31:0]     branch_cnt_o;
    logic [31:0]     mispredict_cnt_o;

    modport master (
        output pc_f_i, br_valid_x_i, pc_x_i, taken_x_i, target_x_i,
               pred_taken_x_i, pred_target_x_i,
        input  pred_hit_f_o, pred_taken_f_o, pred_target_f_o,
               mispredict_x_o, redirect_pc_x_o, branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  pc_f_i, br_valid_x_i, pc_x_i, taken_x_i, target_x_i,
               pred_taken_x_i, pred_target_x_i,
        output pred_hit_f_o, pred_taken_f_o, pred_target_f_o,
               mispredict_x_o, redirect_pc_x_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : fetch lookup (zero-latency, combinational from the table),
//                  execute resolution (combinational mispredict/redirect,
//                  registered table update), branch/mispredict statistics.
module btb_branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned XLEN    = 32
) (
    input logic                   clk_i,
    input logic                   rst_i,
    btb_branch_predictor_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    // Table state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Address split
    logic [IDX_W-1:0] idx_f, idx_x;
    logic [TAG_W-1:0] tag_f, tag_x;
    logic             hit_f, taken_f, hit_x, mispredict_c;

    assign idx_f = bus.pc_f_i[IDX_W+1:2];
    assign tag_f = bus.pc_f_i[XLEN-1:IDX_W+2];
    assign idx_x = bus.pc_x_i[IDX_W+1:2];
    assign tag_x = bus.pc_x_i[XLEN-1:IDX_W+2];

    // Fetch lookup reads the registered table, so a same-cycle update is not visible
    assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign taken_f = hit_f && ctr_q[idx_f][1];

    assign bus.pred_hit_f_o    = hit_f;
    assign bus.pred_taken_f_o  = taken_f;
    assign bus.pred_target_f_o = taken_f ? target_q[idx_f] : bus.pc_f_i + XLEN'(4);

    // Wrong direction, or right "taken" direction with the wrong target
    assign mispredict_c = bus.br_valid_x_i &&
                          ((bus.pred_taken_x_i != bus.taken_x_i) ||
                           (bus.pred_taken_x_i && bus.taken_x_i &&
                            (bus.pred_target_x_i != bus.target_x_i)));

    assign bus.mispredict_x_o  = mispredict_c;
    assign bus.redirect_pc_x_o = !bus.br_valid_x_i ? '0 :
                                 bus.taken_x_i     ? bus.target_x_i :
                                                     bus.pc_x_i + XLEN'(4);

    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;

    assign hit_x = valid_q[idx_x] && (tag_q[idx_x] == tag_x);

    // Next-state for the table entry touched by the resolving branch
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.br_valid_x_i) begin
            if (hit_x) begin
                if (bus.taken_x_i) begin
                    ctr_d[idx_x]    = (ctr_q[idx_x] == 2'b11) ? 2'b11 : ctr_q[idx_x] + 2'd1;
                    target_d[idx_x] = bus.target_x_i;
                end else begin
                    ctr_d[idx_x]    = (ctr_q[idx_x] == 2'b00) ? 2'b00 : ctr_q[idx_x] - 2'd1;
                end
            end else if (bus.taken_x_i) begin
                // Allocate over whatever occupies the slot, starting weak-taken
                valid_d[idx_x]  = 1'b1;
                tag_d[idx_x]    = tag_x;
                target_d[idx_x] = bus.target_x_i;
                ctr_d[idx_x]    = 2'b10;
            end
        end
    end

    // Statistics next-state
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (bus.br_valid_x_i) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict_c) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    // Valid bits, counters and statistics; reset overrides any update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q          <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q          <= valid_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            ctr_q            <= ctr_d;
        end
    end

    // Tag and target payload carry no reset value
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_btb_branch_predictor.sv
// Self-checking bench for btb_branch_predictor (ENTRIES=16, XLEN=32).
module tb_btb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_branch_predictor_if #(.XLEN(32)) bus ();
    btb_branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model of the table and statistics
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_ctr   [16];
    logic [31:0] m_bcnt, m_mcnt;

    function automatic obs_t sample();
        obs_t o;
        o.hit   = bus.pred_hit_f_o;
        o.tk    = bus.pred_taken_f_o;
        o.tgt   = bus.pred_target_f_o;
        o.mis   = bus.mispredict_x_o;
        o.redir = bus.redirect_pc_x_o;
        o.bcnt  = bus.branch_cnt_o;
        o.mcnt  = bus.mispredict_cnt_o;
        return o;
    endfunction

    // Drive one cycle of inputs and push the model's expected outputs
    task automatic drive(input logic [31:0] pcf, input logic bv, input logic [31:0] pcx,
                         input logic tk, input logic [31:0] tx, input logic ptk,
                         input logic [31:0] ptx, input logic r);
        obs_t       e;
        logic [3:0] i;
        rst                 = r;
        bus.pc_f_i          = pcf;
        bus.br_valid_x_i    = bv;
        bus.pc_x_i          = pcx;
        bus.taken_x_i       = tk;
        bus.target_x_i      = tx;
        bus.pred_taken_x_i  = ptk;
        bus.pred_target_x_i = ptx;
        i       = pcf[5:2];
        e.hit   = m_valid[i] && (m_tag[i] == pcf[31:6]);
        e.tk    = e.hit && m_ctr[i][1];
        e.tgt   = e.tk ? m_tgt[i] : pcf + 32'd4;
        e.mis   = bv && ((ptk != tk) || (ptk && tk && (ptx != tx)));
        e.redir = !bv ? 32'd0 : (tk ? tx : pcx + 32'd4);
        e.bcnt  = m_bcnt;
        e.mcnt  = m_mcnt;
        exp_q.push_back(e);
        #2;
    endtask

    // Apply the clock edge to the model and the DUT
    task automatic tick();
        logic [3:0] i;
        logic       h, m;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 2'b01;
            end
            m_bcnt = 0;
            m_mcnt = 0;
        end else if (bus.br_valid_x_i) begin
            i = bus.pc_x_i[5:2];
            h = m_valid[i] && (m_tag[i] == bus.pc_x_i[31:6]);
            m = (bus.pred_taken_x_i != bus.taken_x_i) ||
                (bus.pred_taken_x_i && bus.taken_x_i && (bus.pred_target_x_i != bus.target_x_i));
            m_bcnt = m_bcnt + 32'd1;
            if (m) m_mcnt = m_mcnt + 32'd1;
            if (h) begin
                if (bus.taken_x_i) begin
                    if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
                    m_tgt[i] = bus.target_x_i;
                end else if (m_ctr[i] != 2'b00) begin
                    m_ctr[i] = m_ctr[i] - 2'd1;
                end
            end else if (bus.taken_x_i) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = bus.pc_x_i[31:6];
                m_tgt[i]   = bus.target_x_i;
                m_ctr[i]   = 2'b10;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 32'h104, 1'b1);
        e = exp_q.pop_front();   // table state before the first reset is unknown
        tick();
        // Reset held together with a valid branch: no allocation, no counting
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 32'h104, 1'b1);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
        tick();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_lookup got=%h exp=%h", got, e); end
        n_checks++;
        if (got.hit !== 1'b0 || got.tk !== 1'b0 || got.tgt !== 32'h104 || got.bcnt !== 32'd0 || got.mcnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_values got=%h required hit=0 taken=0 tgt=104 cnt=0", got);
        end
        tick();
    endtask

    task automatic test_allocate();
        obs_t got, e;
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 32'h104, 1'b0);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL alloc_resolve got=%h exp=%h", got, e); end
        tick();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL alloc_lookup got=%h exp=%h", got, e); end
        n_checks++;
        if (got.hit !== 1'b1 || got.tk !== 1'b1 || got.tgt !== 32'h180 || got.mcnt !== 32'd1) begin
            n_fail++; $display("FAIL alloc_values got=%h required hit=1 taken=1 tgt=180 mcnt=1", got);
        end
        tick();
    endtask

    // Counter walk including saturation at both ends
    task automatic test_counter();
        obs_t got, e;
        logic bv, tk, ptk;
        logic [31:0] ptx;
        for (int s = 0; s < 10; s++) begin
            bv = 1'b1; tk = 1'b0; ptk = 1'b0; ptx = 32'h104;
            case (s)
                0:       begin ptk = 1'b1; ptx = 32'h180; end
                3, 5:    tk = 1'b1;
                4, 9:    bv = 1'b0;
                6, 7:    begin tk = 1'b1; ptk = 1'b1; ptx = 32'h180; end
                8:       begin ptk = 1'b1; ptx = 32'h180; end
                default: ;
            endcase
            drive(32'h100, bv, 32'h100, tk, 32'h180, ptk, ptx, 1'b0);
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL counter_step%0d got=%h exp=%h", s, got, e); end
            if (s == 0) begin
                n_checks++;
                if (got.redir !== 32'h104 || got.mis !== 1'b1) begin
                    n_fail++; $display("FAIL counter_nt_redirect got=%h required redir=104 mis=1", got.redir);
                end
            end
            tick();
        end
    endtask

    task automatic test_alias();
        obs_t got, e;
        for (int s = 0; s < 3; s++) begin
            if (s == 0) drive(32'h100, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144, 1'b0);
            else        drive((s == 1) ? 32'h100 : 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL alias_step%0d got=%h exp=%h", s, got, e); end
            if (s == 1) begin
                n_checks++;
                if (got.hit !== 1'b0) begin n_fail++; $display("FAIL alias_evict hit=%b required 0", got.hit); end
            end
            tick();
        end
    endtask

    task automatic test_wrong_target();
        obs_t got, e;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 32'h104, 1'b0);
                1:       drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h1C0, 1'b1, 32'h180, 1'b0);
                default: drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            endcase
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL wrong_tgt_step%0d got=%h exp=%h", s, got, e); end
            if (s == 1) begin
                n_checks++;
                if (got.mis !== 1'b1 || got.redir !== 32'h1C0) begin
                    n_fail++; $display("FAIL wrong_tgt_redirect mis=%b redir=%h required 1/1c0", got.mis, got.redir);
                end
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        obs_t got, e;
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h240, 1'b1, 32'h1C0, 1'b0);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL same_cycle_old got=%h exp=%h", got, e); end
        n_checks++;
        if (got.tgt !== 32'h1C0) begin n_fail++; $display("FAIL same_cycle_bypass tgt=%h required 1c0", got.tgt); end
        tick();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL same_cycle_new got=%h exp=%h", got, e); end
        tick();
    endtask

    task automatic test_idle();
        obs_t got, e;
        for (int s = 0; s < 3; s++) begin
            drive(32'h140, 1'b0, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104, 1'b0);
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL idle_step%0d got=%h exp=%h", s, got, e); end
            tick();
        end
    endtask

    task automatic test_random();
        obs_t got, e;
        logic [31:0] pcs [6];
        logic [31:0] tgts [3];
        logic [31:0] pcf, pcx, tx, ptx;
        logic        bv, tk, ptk, h;
        logic [3:0]  i;
        pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h104;
        pcs[3] = 32'h200; pcs[4] = 32'h3FE; pcs[5] = 32'h1100;
        tgts[0] = 32'h180; tgts[1] = 32'h1C0; tgts[2] = 32'h800;
        for (int s = 0; s < 200; s++) begin
            pcf = pcs[$urandom_range(0, 5)];
            pcx = pcs[$urandom_range(0, 5)];
            tx  = tgts[$urandom_range(0, 2)];
            bv  = ($urandom_range(0, 3) != 0);
            tk  = $urandom_range(0, 1) == 1;
            i   = pcx[5:2];
            h   = m_valid[i] && (m_tag[i] == pcx[31:6]);
            ptk = h && m_ctr[i][1];
            ptx = ptk ? m_tgt[i] : pcx + 32'd4;
            if ($urandom_range(0, 3) == 0) ptk = ~ptk;
            drive(pcf, bv, pcx, tk, tx, ptk, ptx, 1'b0);
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL random_step%0d got=%h exp=%h", s, got, e); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, e;
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180, 1'b1);
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_mid_hold got=%h exp=%h", got, e); end
        tick();
        for (int s = 0; s < 2; s++) begin
            drive((s == 0) ? 32'h100 : 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL reset_mid_lookup%0d got=%h exp=%h", s, got, e); end
            n_checks++;
            if (got.hit !== 1'b0 || got.bcnt !== 32'd0 || got.mcnt !== 32'd0) begin
                n_fail++; $display("FAIL reset_mid_cleared got=%h required hit=0 cnt=0", got);
            end
            tick();
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.pc_f_i          = '0;
        bus.br_valid_x_i    = 1'b0;
        bus.pc_x_i          = '0;
        bus.taken_x_i       = 1'b0;
        bus.target_x_i      = '0;
        bus.pred_taken_x_i  = 1'b0;
        bus.pred_target_x_i = '0;
        m_bcnt = 0;
        m_mcnt = 0;
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 2'b01;
            m_tag[k]   = '0;
            m_tgt[k]   = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_wrong_target();
        test_same_cycle();
        test_idle();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_branch_predictor.md
Name: btb_branch_predictor

Overview:
Fetch-side prediction and execute-side resolution unit for the RV32I pipeline. It holds a direct-mapped branch target buffer. Each entry carries a 2-bit saturating direction counter, and the fetch stage reads the buffer every cycle to choose the next PC. The execute stage writes each resolved conditional branch back into the buffer and gets a mispredict/redirect decision from the block.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2.
IDX_W, $clog2(ENTRIES), index width; derived, do not override.
XLEN, 32, PC width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
pc_f_i  in  XLEN  PC of the instruction being fetched.
pred_hit_f_o  out  1  lookup hit: valid entry with matching tag.
pred_taken_f_o  out  1  predicted taken (hit and counter[1]=1).
pred_target_f_o  out  XLEN  next PC for fetch: stored target if pred_taken_f_o, else pc_f_i+4.
br_valid_x_i  in  1  a conditional branch (opcode 1100011) is resolved in X this cycle.
pc_x_i  in  XLEN  PC of the resolved branch.
taken_x_i  in  1  actual branch outcome.
target_x_i  in  XLEN  actual branch target (pc_x_i + imm).
pred_taken_x_i  in  1  prediction piped from F for this branch.
pred_target_x_i  in  XLEN  predicted next PC piped from F.
mispredict_x_o  out  1  prediction wrong; flush F/D and redirect.
redirect_pc_x_o  out  XLEN  correct next PC: target_x_i if taken_x_i, else pc_x_i+4.
branch_cnt_o  out  32  resolved-branch counter.
mispredict_cnt_o  out  32  mispredict counter.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
- Entry fields: valid, tag, target, ctr[1:0]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from pc_f_i and the registered table, so it has zero latency.
- On a miss, pred_hit_f_o=0, pred_taken_f_o=0 and pred_target_f_o=pc_f_i+4.
- mispredict_x_o and redirect_pc_x_o are combinational and gated by br_valid_x_i; both are 0 when br_valid_x_i=0.
- mispredict_x_o=1 when pred_taken_x_i != taken_x_i.
- mispredict_x_o=1 also when both pred_taken_x_i and taken_x_i are 1 and pred_target_x_i != target_x_i.
- Table update is registered at the clock edge when br_valid_x_i=1:
  - Hit, taken: ctr saturating +1 (11 stays 11); target <= target_x_i.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate (replacing any occupant) with valid=1, tag, target=target_x_i, ctr=10.
  - Miss, not taken: no write.
- Same-cycle read and write of one index: fetch sees the pre-update contents; no bypass. The new value is visible on the next cycle.
- Counters: branch_cnt_o increments once per br_valid_x_i; mispredict_cnt_o increments when mispredict_x_o=1. Both wrap modulo 2^32.
- Reset, while rst_i=1 at an edge:
  - All valid bits clear, all ctr=01, both stat counters = 0.
  - Tag and target contents are don't-care.
  - Updates are suppressed during reset; reset wins over a simultaneous br_valid_x_i.
  - Reset mid-operation discards all learned history.
- After reset every lookup misses, so pred_* outputs show the miss values.
- An X-stage update from the same PC as the F-stage PC is legal and follows the same-cycle rule above.

Test Plan:
1. Reset, then pc_f_i=0x100 -> pred_hit_f_o=0, pred_taken_f_o=0, pred_target_f_o=0x104; both stat counters 0.
2. Resolve pc_x=0x100, taken, target=0x180, pred_taken=0 -> mispredict_x_o=1, redirect_pc_x_o=0x180. Next cycle pc_f_i=0x100 -> hit=1, taken=1, target=0x180; mispredict_cnt_o=1.
3. Same branch resolved not-taken twice -> ctr 10->01->00. Lookup predicts not-taken, target=0x104. With pred_taken=1 on the first resolve, redirect_pc_x_o=0x104.
4. Aliasing, ENTRIES=16: pc 0x100 allocated, then pc 0x140 taken to 0x200 (same index, different tag) -> 0x100 now misses, 0x140 hits with target 0x200.
5. Taken with correct direction but wrong target: pred_target=0x180, target_x=0x1C0 -> mispredict_x_o=1, redirect=0x1C0, entry target becomes 0x1C0.
6. Same-cycle update and lookup of 0x100 -> the F output shows the old entry and the next cycle shows the new one. Assert rst_i together with br_valid_x_i -> no allocation, counters 0.
